// File: rtl/pc_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit_if
// Bundle of every signal between the IF-stage fetch sequencer and its
// neighbours: the decode-side stall and redirect requests, the instruction
// memory request/response handshake, and the buffered instruction that is
// handed to decode.
//
//   stall       decode not accepting the buffered instruction
//   br_taken    taken-branch redirect request
//   br_target   branch target address
//   jmp_valid   jump / jr redirect request
//   jmp_target  jump target address
//   imem_req    fetch request
//   imem_addr   word-aligned fetch address
//   imem_ready  memory completes the current request this cycle
//   imem_rdata  instruction word returned by memory
//   if_valid    buffered instruction is valid
//   if_instr    buffered instruction
//   if_pc       address of if_instr
//   if_npc      if_pc + 4
//
// master: the fetch unit side.  slave: the environment (decode + memory).
// ---------------------------------------------------------------------------
interface pc_fetch_unit_if;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp_valid;
  logic [31:0] jmp_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_npc;

  modport master (
    input  stall, br_taken, br_target, jmp_valid, jmp_target,
    input  imem_ready, imem_rdata,
    output imem_req, imem_addr,
    output if_valid, if_instr, if_pc, if_npc
  );

  modport slave (
    output stall, br_taken, br_target, jmp_valid, jmp_target,
    output imem_ready, imem_rdata,
    input  imem_req, imem_addr,
    input  if_valid, if_instr, if_pc, if_npc
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
// Program counter and instruction-fetch sequencer for the IF stage.  Issues
// one word fetch at a time, buffers one fetched instruction for decode (plus
// a single overflow "hold" entry when decode stalls while a fetch lands),
// and redirects on taken branches / jumps, discarding wrong-path data.
//
// Ports
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    pc_fetch_unit_if.master (stall, redirects, imem handshake,
//          if_valid / if_instr / if_pc / if_npc)
//
// Parameters
//   RESET_PC  fetch address after reset
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic             clk,
  input  logic             reset,
  pc_fetch_unit_if.master  bus
);

  typedef enum logic {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] fetch_pc;
  logic [31:0] redir_pc;
  logic        kill_q;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;

  logic        if_valid_q;
  logic [31:0] if_instr_q;
  logic [31:0] if_pc_q;
  logic [31:0] if_npc_q;

  logic        req;
  logic        ready;
  logic        redirect;
  logic        buf_free;
  logic [31:0] tgt;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  // Modulo-2^32 increment: 0xFFFF_FFFC wraps to 0.
  function automatic logic [31:0] pc_inc(input logic [31:0] a);
    return a + 32'd4;
  endfunction

  // Request decode shared by the FSM and the datapath.
  always_comb begin
    redirect = bus.br_taken || bus.jmp_valid;
    // Branch has priority when both redirects arrive together.
    tgt      = word_align(bus.br_taken ? bus.br_target : bus.jmp_target);
    // Memory responses only count while a request is actually outstanding.
    ready    = bus.imem_ready && req;
    buf_free = !if_valid_q || !bus.stall;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_REQ;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ: begin
        // A good fetch that cannot enter the buffer parks in the hold entry.
        if (ready && !redirect && !kill_q && !buf_free) begin
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect || buf_free) begin
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req           = (state == S_REQ) && !reset;
    bus.imem_req  = req;
    bus.imem_addr = word_align(fetch_pc);
  end

  // Fetch address, wrong-path kill tracking, hold entry and decode buffer.
  // Later assignments in this block take priority: a redirect always wins
  // over the load/consume updates of if_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc   <= word_align(RESET_PC);
      kill_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      if_npc_q   <= '0;
    end else begin
      if (if_valid_q && !bus.stall) begin
        if_valid_q <= 1'b0;
      end

      case (state)
        S_REQ: begin
          if (ready && (redirect || kill_q)) begin
            // Returning data belongs to the abandoned path.
            fetch_pc <= redirect ? tgt : redir_pc;
            kill_q   <= 1'b0;
          end else if (redirect) begin
            // Address must stay stable until the memory answers, so the
            // target is parked and the in-flight word is marked for discard.
            redir_pc <= tgt;
            kill_q   <= 1'b1;
          end else if (ready && buf_free) begin
            if_valid_q <= 1'b1;
            if_instr_q <= bus.imem_rdata;
            if_pc_q    <= fetch_pc;
            if_npc_q   <= pc_inc(fetch_pc);
            fetch_pc   <= pc_inc(fetch_pc);
          end else if (ready) begin
            hold_instr <= bus.imem_rdata;
            hold_pc    <= fetch_pc;
            fetch_pc   <= pc_inc(fetch_pc);
          end
        end
        S_HOLD: begin
          if (redirect) begin
            fetch_pc <= tgt;
          end else if (buf_free) begin
            if_valid_q <= 1'b1;
            if_instr_q <= hold_instr;
            if_pc_q    <= hold_pc;
            if_npc_q   <= pc_inc(hold_pc);
          end
        end
        default: ;
      endcase

      // No delay slots: a redirect flushes the buffered instruction.
      if (redirect) begin
        if_valid_q <= 1'b0;
      end
    end
  end

  assign bus.if_valid = if_valid_q;
  assign bus.if_instr = if_instr_q;
  assign bus.if_pc    = if_pc_q;
  assign bus.if_npc   = if_npc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit
// Bench for pc_fetch_unit: a latency-programmable instruction memory, a
// stream-level reference model (expected program-order address sequence,
// reset to 0x3000 and re-seeded by every redirect), directed scenarios and a
// randomized phase.
// ---------------------------------------------------------------------------
module tb_pc_fetch_unit;

  logic clk;
  logic reset;

  int n_assert = 0;
  int n_fail   = 0;

  int mem_lat   = 0;   // wait cycles before imem_ready
  bit idle_rdy  = 1'b1; // ready driven high while no request is pending
  bit idle_rand = 1'b0; // random ready while no request is pending
  bit mon_en    = 1'b0;
  int consumed  = 0;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs applied at the falling edge, results visible
  // 3 time units later (after the memory model and monitor have run).
  task automatic cyc(input logic r, input logic st, input logic bt,
                     input logic [31:0] btg, input logic jv, input logic [31:0] jtg);
    @(negedge clk);
    reset          = r;
    bus.stall      = st;
    bus.br_taken   = bt;
    bus.br_target  = btg;
    bus.jmp_valid  = jv;
    bus.jmp_target = jtg;
    #3;
  endtask

  task automatic idle(input logic st);
    cyc(1'b0, st, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Instruction memory: answers a request after mem_lat wait cycles.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    bus.imem_ready = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (bus.imem_req === 1'b1) begin
        bus.imem_ready = (wait_cnt >= mem_lat);
        bus.imem_rdata = bus.imem_ready ? mem_word(bus.imem_addr) : $urandom;
        wait_cnt       = bus.imem_ready ? 0 : wait_cnt + 1;
      end else begin
        wait_cnt       = 0;
        bus.imem_ready = idle_rdy ? 1'b1 : (idle_rand ? 1'($urandom_range(0, 1)) : 1'b0);
        bus.imem_rdata = $urandom;
      end
    end
  end

  // Stream-level reference: decode must see consecutive words starting at
  // the reset address or the latest redirect target, each carrying memory
  // contents for its address, with stable requests and flushes honoured.
  initial begin
    logic [31:0] exp_pc;
    logic [31:0] prev_addr;
    bit          prev_pend;
    bit          prev_rst;
    bit          prev_redir;
    exp_pc     = 32'h3000;
    prev_addr  = '0;
    prev_pend  = 1'b0;
    prev_rst   = 1'b1;
    prev_redir = 1'b0;
    wait (mon_en);
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        check("req_in_reset", {31'h0, bus.imem_req}, 32'h0);
        exp_pc    = 32'h3000;
        prev_pend = 1'b0;
      end else begin
        if (bus.imem_req) begin
          check("addr_aligned", {30'h0, bus.imem_addr[1:0]}, 32'h0);
        end
        if (prev_pend) begin
          check("req_held", {31'h0, bus.imem_req}, 32'h1);
          check("addr_stable", bus.imem_addr, prev_addr);
        end
        if (prev_rst || prev_redir) begin
          check("valid_after_flush", {31'h0, bus.if_valid}, 32'h0);
        end
        if (bus.if_valid && !bus.stall) begin
          check("stream_pc", bus.if_pc, exp_pc);
          check("stream_instr", bus.if_instr, mem_word(bus.if_pc));
          check("stream_npc", bus.if_npc, bus.if_pc + 32'd4);
          exp_pc = exp_pc + 32'd4;
          consumed++;
        end
        if (bus.br_taken || bus.jmp_valid) begin
          exp_pc = (bus.br_taken ? bus.br_target : bus.jmp_target) & 32'hFFFF_FFFC;
        end
        prev_pend = bus.imem_req && !bus.imem_ready;
        prev_addr = bus.imem_addr;
      end
      prev_rst   = reset;
      prev_redir = !reset && (bus.br_taken || bus.jmp_valid);
    end
  end

  initial begin
    bit found;
    int base;
    reset          = 1'b1;
    bus.stall      = 1'b0;
    bus.br_taken   = 1'b0;
    bus.br_target  = '0;
    bus.jmp_valid  = 1'b0;
    bus.jmp_target = '0;

    // 1: reset then back-to-back fetches with a zero-wait memory
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    mon_en = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("t1_reset_valid", {31'h0, bus.if_valid}, 32'h0);
    check("t1_reset_pc", bus.if_pc, 32'h0);
    idle(1'b0);
    check("t1_addr0", bus.imem_addr, 32'h3000);
    check("t1_req0", {31'h0, bus.imem_req}, 32'h1);
    check("t1_valid0", {31'h0, bus.if_valid}, 32'h0);
    idle(1'b0);
    check("t1_addr1", bus.imem_addr, 32'h3004);
    check("t1_valid1", {31'h0, bus.if_valid}, 32'h1);
    check("t1_pc1", bus.if_pc, 32'h3000);
    check("t1_npc1", bus.if_npc, 32'h3004);
    idle(1'b0);
    check("t1_addr2", bus.imem_addr, 32'h3008);

    // 2: stall with the buffer full sends the next word to hold
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(1'b1);
    idle(1'b1);
    check("t2_addr_hold", bus.imem_addr, 32'h3004);
    idle(1'b1);
    check("t2_req_hold", {31'h0, bus.imem_req}, 32'h0);
    check("t2_pc_hold", bus.if_pc, 32'h3000);
    idle(1'b0);
    check("t2_pc_a", bus.if_pc, 32'h3000);
    idle(1'b0);
    check("t2_pc_b", bus.if_pc, 32'h3004);
    check("t2_req_back", {31'h0, bus.imem_req}, 32'h1);
    check("t2_addr_c", bus.imem_addr, 32'h3008);
    idle(1'b0);
    check("t2_pc_c", bus.if_pc, 32'h3008);

    // 3: branch during a multi-cycle fetch discards the returning word
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(1'b0);
    idle(1'b0);
    mem_lat = 2;
    cyc(1'b0, 1'b0, 1'b1, 32'h3040, 1'b0, 32'h0);
    check("t3_addr_w0", bus.imem_addr, 32'h3008);
    idle(1'b0);
    check("t3_addr_w1", bus.imem_addr, 32'h3008);
    check("t3_valid_w1", {31'h0, bus.if_valid}, 32'h0);
    idle(1'b0);
    check("t3_ready", {31'h0, bus.imem_ready}, 32'h1);
    check("t3_addr_w2", bus.imem_addr, 32'h3008);
    idle(1'b0);
    check("t3_addr_tgt", bus.imem_addr, 32'h3040);
    check("t3_valid_tgt", {31'h0, bus.if_valid}, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      idle(1'b0);
      found = bus.if_valid;
    end
    check("t3_first_valid_seen", {31'h0, found}, 32'h1);
    check("t3_first_pc", bus.if_pc, 32'h3040);
    mem_lat = 0;

    // 4: simultaneous branch and jump, then an unaligned target
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 32'h3100, 1'b1, 32'h3200);
    idle(1'b0);
    check("t4_branch_wins", bus.imem_addr, 32'h3100);
    check("t4_valid", {31'h0, bus.if_valid}, 32'h0);
    bus.br_target = 32'h3103;
    cyc(1'b0, 1'b0, 1'b1, 32'h3103, 1'b0, 32'h0);
    idle(1'b0);
    check("t4_align", bus.imem_addr, 32'h3100);
    idle(1'b0);
    check("t4_pc", bus.if_pc, 32'h3100);

    // 5: wrap-around at the top of the address space
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    idle(1'b0);
    check("t5_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
    idle(1'b0);
    check("t5_pc", bus.if_pc, 32'hFFFF_FFFC);
    check("t5_npc_wrap", bus.if_npc, 32'h0);
    check("t5_addr_wrap", bus.imem_addr, 32'h0);

    // 6: reset during an outstanding request and during hold
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    mem_lat = 3;
    idle(1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("t6_req_rst_a", {31'h0, bus.imem_req}, 32'h0);
    check("t6_valid_rst_a", {31'h0, bus.if_valid}, 32'h0);
    mem_lat = 0;
    idle(1'b0);
    check("t6_resume_a", bus.imem_addr, 32'h3000);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    check("t6_in_hold", {31'h0, bus.imem_req}, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("t6_req_rst_b", {31'h0, bus.imem_req}, 32'h0);
    idle(1'b0);
    check("t6_valid_rst_b", {31'h0, bus.if_valid}, 32'h0);
    check("t6_resume_b", bus.imem_addr, 32'h3000);
    check("t6_req_b", {31'h0, bus.imem_req}, 32'h1);
    idle(1'b0);
    check("t6_pc_b", bus.if_pc, 32'h3000);

    // Randomized traffic checked by the stream reference
    idle_rdy  = 1'b0;
    idle_rand = 1'b1;
    base      = consumed;
    for (int i = 0; i < 4000; i++) begin
      logic        r;
      logic        st;
      logic        bt;
      logic        jv;
      logic [31:0] btg;
      logic [31:0] jtg;
      if ($urandom_range(0, 39) == 0) mem_lat = $urandom_range(0, 3);
      r   = ($urandom_range(0, 199) == 0);
      st  = ($urandom_range(0, 9) < 4);
      bt  = ($urandom_range(0, 19) == 0);
      jv  = ($urandom_range(0, 19) == 0);
      btg = $urandom;
      jtg = $urandom;
      if ($urandom_range(0, 9) == 0) jtg = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      cyc(r, st, bt, btg, jv, jtg);
    end
    check("rand_progress", {31'h0, (consumed - base) > 300}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
